// File: rtl/x_byte_ser.sv
// x_byte_ser: word-to-byte serializer, least-significant byte first.
// Accepts one 8*BYTES-bit word on a valid/accept handshake and streams its
// bytes out on a second valid/accept handshake toward x_uart_tx.
// Optional feature: define X_BYTE_SER_CSUM_EN to append one XOR checksum byte
// after the data bytes of every word.
module x_byte_ser #(
  parameter int unsigned BYTES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_accept,
  input  logic [8*BYTES-1:0] i_data,
  output logic               o_valid,
  input  logic               i_accept,
  output logic [7:0]         o_data,
  output logic               o_busy
);

  localparam int unsigned W    = 8 * BYTES;
  localparam int unsigned CW   = $clog2(BYTES);
  localparam int unsigned LAST = BYTES - 1;

`ifdef X_BYTE_SER_CSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

  state_t         state;
  logic [W-1:0]   word;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [W-1:0]   word_shr;
`ifdef X_BYTE_SER_CSUM_EN
  logic [7:0]     csum;
`endif

  // Index of the next byte and the word shifted so that byte sits in [7:0].
  assign cnt_nxt  = cnt + CW'(1);
  assign word_shr = word >> {cnt_nxt, 3'b000};

  // Serializer FSM; all outputs are registered and change with the state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      word     <= '0;
      cnt      <= '0;
`ifdef X_BYTE_SER_CSUM_EN
      csum     <= 8'h00;
`endif
      o_valid  <= 1'b0;
      o_data   <= 8'h00;
      o_accept <= 1'b1;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            word     <= i_data;
            cnt      <= '0;
`ifdef X_BYTE_SER_CSUM_EN
            csum     <= 8'h00;
`endif
            o_data   <= i_data[7:0];
            o_valid  <= 1'b1;
            o_accept <= 1'b0;
            o_busy   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_accept) begin
`ifdef X_BYTE_SER_CSUM_EN
            csum <= csum ^ o_data;
`endif
            if (cnt == CW'(LAST)) begin
`ifdef X_BYTE_SER_CSUM_EN
              // Fold the last data byte in directly so the checksum shows next cycle.
              o_data <= csum ^ o_data;
              state  <= CSUM;
`else
              o_valid  <= 1'b0;
              o_accept <= 1'b1;
              o_busy   <= 1'b0;
              state    <= IDLE;
`endif
            end else begin
              cnt    <= cnt_nxt;
              o_data <= word_shr[7:0];
            end
          end
        end
`ifdef X_BYTE_SER_CSUM_EN
        CSUM: begin
          if (i_accept) begin
            o_valid  <= 1'b0;
            o_accept <= 1'b1;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: begin
          o_valid  <= 1'b0;
          o_accept <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
